// File: rtl/mem_ctrl.sv
// mem_ctrl: sequencer for a byte-wide single-port RAM shared by the instruction
// fetch path and the load/store buffer.
// - A fetch is serviced as four byte reads, assembled little-endian into a word.
// - LSB requests move one byte each and win arbitration over fetches.
// - RAM read data arrives one cycle after its address, so every read is
//   captured one cycle after the address was presented.
module mem_ctrl #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0003_0000)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              _clear,
  input  logic              _if_mem_ready,
  input  logic [ADDR_W-1:0] _if_addr,
  output logic              _mem_if_ready,
  output logic [31:0]       _mem_if_data,
  input  logic              _lsb_mem_ready,
  input  logic              _r_nw_in,
  input  logic [ADDR_W-1:0] _addr,
  input  logic [7:0]        _data_in,
  output logic              _mem_lsb_ready,
  output logic [7:0]        _data_out,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IF_RD   = 3'd1,
    S_IF_TAIL = 3'd2,
    S_LS_RD   = 3'd3,
    S_LS_WAIT = 3'd4,
    S_LS_WR   = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       bytes_q, bytes_d;      // fetch bytes 0..2, byte 3 goes straight out
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_ready_q, if_ready_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              lsb_ready_q, lsb_ready_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              io_blocked_s;
  logic              lsb_accept_s;

  // A store into I/O space is held off while the I/O sink is full
  assign io_blocked_s = ~_r_nw_in & (_addr >= IO_BASE) & io_buffer_full;
  assign lsb_accept_s = _lsb_mem_ready & ~io_blocked_s;

  // Next-state and next-output logic; outputs are computed one edge ahead and registered
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bytes_d     = bytes_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    if_ready_d  = 1'b0;
    if_data_d   = if_data_q;
    lsb_ready_d = 1'b0;
    data_out_d  = data_out_q;

    if (!rdy_in) begin
      // Paused: everything holds so the current cycle replays on resume.
      // The RAM port is assumed stalled by the same rdy, so its read data still lines up.
      mem_wr_d    = mem_wr_q;
      if_ready_d  = if_ready_q;
      lsb_ready_d = lsb_ready_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (_clear) begin
            state_d = S_IDLE;
          end else if (lsb_accept_s) begin
            mem_a_d = _addr;
            if (_r_nw_in) begin
              state_d = S_LS_RD;
            end else begin
              state_d    = S_LS_WR;
              mem_dout_d = _data_in;
              mem_wr_d   = 1'b1;
            end
          end else if (_if_mem_ready) begin
            state_d = S_IF_RD;
            cnt_d   = 2'd0;
            mem_a_d = _if_addr;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_IF_RD: begin
          if (_clear) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
          end else begin
            // Data on mem_din belongs to the previous cycle's address (byte cnt-1)
            case (cnt_q)
              2'd1:    bytes_d[7:0]   = mem_din;
              2'd2:    bytes_d[15:8]  = mem_din;
              2'd3:    bytes_d[23:16] = mem_din;
              default: bytes_d        = bytes_q;
            endcase
            if (cnt_q == 2'd3) begin
              state_d = S_IF_TAIL;
            end else begin
              cnt_d   = cnt_q + 2'd1;
              mem_a_d = mem_a_q + ADDR_ONE;
            end
          end
        end

        S_IF_TAIL: begin
          cnt_d = 2'd0;
          if (_clear) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_DONE;
            if_ready_d = 1'b1;
            if_data_d  = {mem_din, bytes_q};
          end
        end

        S_LS_RD: begin
          if (_clear) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_LS_WAIT;
          end
        end

        S_LS_WAIT: begin
          if (_clear) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_DONE;
            lsb_ready_d = 1'b1;
            data_out_d  = mem_din;
          end
        end

        S_LS_WR: begin
          // Stores are committed: a flush does not cancel the acknowledge
          state_d     = S_DONE;
          lsb_ready_d = 1'b1;
        end

        S_DONE: begin
          // Requests are not sampled here so a requester that drops after the pulse is not re-served
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      bytes_q     <= 24'd0;
      mem_a_q     <= '0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      if_data_q   <= 32'd0;
      lsb_ready_q <= 1'b0;
      data_out_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bytes_q     <= bytes_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_ready_q  <= if_ready_d;
      if_data_q   <= if_data_d;
      lsb_ready_q <= lsb_ready_d;
      data_out_q  <= data_out_d;
    end
  end

  assign mem_a          = mem_a_q;
  assign mem_dout       = mem_dout_q;
  // A paused write must not reach the RAM in the paused cycle itself
  assign mem_wr         = mem_wr_q & rdy_in;
  assign _mem_if_ready  = if_ready_q;
  assign _mem_if_data   = if_data_q;
  assign _mem_lsb_ready = lsb_ready_q;
  assign _data_out      = data_out_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural RAM, an expected-memory model and
// per-scenario tasks that check transaction timing and data.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, rdy, clr, if_req, if_rdy, lsb_req, r_nw, lsb_rdy, mem_wr, io_full;
  logic [31:0] if_addr, if_data, addr, mem_a;
  logic [7:0]  din_lsb, dout_lsb, mem_din, mem_dout;

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;

  logic [7:0] ram   [bit [31:0]];   // contents of the simulated RAM (written by the DUT)
  logic [7:0] model [bit [31:0]];   // what memory should hold

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), ._clear(clr),
    ._if_mem_ready(if_req), ._if_addr(if_addr), ._mem_if_ready(if_rdy), ._mem_if_data(if_data),
    ._lsb_mem_ready(lsb_req), ._r_nw_in(r_nw), ._addr(addr), ._data_in(din_lsb),
    ._mem_lsb_ready(lsb_rdy), ._data_out(dout_lsb),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_full)
  );

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a]; else return fill(a);
  endfunction
  function automatic logic [7:0] model_rd(input logic [31:0] a);
    if (model.exists(a)) return model[a]; else return fill(a);
  endfunction
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {model_rd(a + 32'd3), model_rd(a + 32'd2), model_rd(a + 32'd1), model_rd(a)};
  endfunction

  // RAM: read data one cycle after the address, writes on the clock edge
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) begin
      ram[mem_a] = mem_dout;
      wr_count++;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    model[a] = d;
  endtask

  // Fetch from IDLE; word expected in cycle 6
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] ea;
    if_req = 1'b1; if_addr = a;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        ea = a + 32'(c - 1);
        n_cmp++; if (mem_a !== ea) begin n_err++; $display("FAIL fetch_mem_a c%0d: got %h want %h", c, mem_a, ea); end
      end
      n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL fetch_mem_wr c%0d: got %b want 0", c, mem_wr); end
      if (c == 6) begin
        n_cmp++; if (if_rdy !== 1'b1 || if_data !== exp) begin n_err++; $display("FAIL fetch_word: got %b/%h want 1/%h", if_rdy, if_data, exp); end
        if_req = 1'b0;
      end else begin
        n_cmp++; if (if_rdy !== 1'b0) begin n_err++; $display("FAIL fetch_pulse c%0d: got %b want 0", c, if_rdy); end
      end
    end
  endtask

  // LSB read from IDLE; byte expected in cycle 3
  task automatic do_read(input logic [31:0] a);
    logic [7:0] exp;
    exp = model_rd(a);
    lsb_req = 1'b1; r_nw = 1'b1; addr = a;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (mem_a !== a || mem_wr !== 1'b0) begin n_err++; $display("FAIL read_addr: got %h/%b want %h/0", mem_a, mem_wr, a); end
      end
      if (c == 3) begin
        n_cmp++; if (lsb_rdy !== 1'b1 || dout_lsb !== exp) begin n_err++; $display("FAIL read_data: got %b/%h want 1/%h", lsb_rdy, dout_lsb, exp); end
        lsb_req = 1'b0;
      end else begin
        n_cmp++; if (lsb_rdy !== 1'b0) begin n_err++; $display("FAIL read_pulse c%0d: got %b want 0", c, lsb_rdy); end
      end
    end
  endtask

  // LSB write from IDLE; write in cycle 1, ack in cycle 2
  task automatic do_write(input logic [31:0] a, input logic [7:0] d);
    int w0;
    w0 = wr_count;
    lsb_req = 1'b1; r_nw = 1'b0; addr = a; din_lsb = d;
    @(negedge clk);
    n_cmp++; if (mem_wr !== 1'b1 || mem_a !== a || mem_dout !== d) begin n_err++; $display("FAIL write_bus: got %b/%h/%h want 1/%h/%h", mem_wr, mem_a, mem_dout, a, d); end
    n_cmp++; if (lsb_rdy !== 1'b0) begin n_err++; $display("FAIL write_early_ack: got %b want 0", lsb_rdy); end
    @(negedge clk);
    n_cmp++; if (lsb_rdy !== 1'b1 || mem_wr !== 1'b0) begin n_err++; $display("FAIL write_ack: got %b/%b want 1/0", lsb_rdy, mem_wr); end
    lsb_req = 1'b0;
    model[a] = d;
    @(negedge clk);
    n_cmp++; if (lsb_rdy !== 1'b0 || wr_count !== w0 + 1 || ram_rd(a) !== d) begin n_err++; $display("FAIL write_commit: got ack %b writes %0d byte %h want 0 %0d %h", lsb_rdy, wr_count - w0, ram_rd(a), 1, d); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({mem_a, mem_dout, mem_wr, if_rdy, if_data, lsb_rdy, dout_lsb} !== 83'd0) begin n_err++; $display("FAIL reset_outputs: got %h/%h/%b/%b/%h/%b/%h want all 0", mem_a, mem_dout, mem_wr, if_rdy, if_data, lsb_rdy, dout_lsb); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_a !== 32'd0 || if_rdy !== 1'b0 || lsb_rdy !== 1'b0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_idle: got %h/%b/%b/%b want 0/0/0/0", mem_a, if_rdy, lsb_rdy, mem_wr); end
  endtask

  task automatic test_fetch();
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    do_fetch(32'h1000, 32'h0000_0513);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = $urandom;
      do_fetch(a, word_at(a));
    end
  endtask

  task automatic test_lsb();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic [7:0]  d;
      a = $urandom_range(32'h0002_FFF0, 32'h0000_0100);
      d = 8'($urandom);
      do_write(a, d);
      do_read(a);
    end
  endtask

  task automatic test_priority();
    logic [31:0] fa;
    fa = $urandom_range(32'h0000_0FFF, 32'h0000_0100);
    preload(32'h20, 8'hAB);
    lsb_req = 1'b1; r_nw = 1'b1; addr = 32'h20; if_req = 1'b1; if_addr = fa;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (mem_a !== 32'h20) begin n_err++; $display("FAIL prio_lsb_first: got %h want 00000020", mem_a); end
      end
      if (c == 3) begin
        n_cmp++; if (lsb_rdy !== 1'b1 || dout_lsb !== 8'hAB) begin n_err++; $display("FAIL prio_read: got %b/%h want 1/ab", lsb_rdy, dout_lsb); end
        lsb_req = 1'b0;
      end
      if (c >= 5 && c <= 8) begin
        n_cmp++; if (mem_a !== fa + 32'(c - 5)) begin n_err++; $display("FAIL prio_fetch_a c%0d: got %h want %h", c, mem_a, fa + 32'(c - 5)); end
      end
      if (c == 10) begin
        n_cmp++; if (if_rdy !== 1'b1 || if_data !== word_at(fa)) begin n_err++; $display("FAIL prio_fetch: got %b/%h want 1/%h", if_rdy, if_data, word_at(fa)); end
        if_req = 1'b0;
      end else begin
        n_cmp++; if (if_rdy !== 1'b0) begin n_err++; $display("FAIL prio_if_pulse c%0d: got %b want 0", c, if_rdy); end
      end
    end
  endtask

  task automatic test_io();
    int w0;
    logic [31:0] fa;
    w0 = wr_count;
    io_full = 1'b1;
    lsb_req = 1'b1; r_nw = 1'b0; addr = 32'h0003_0000; din_lsb = 8'h41;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_wr !== 1'b0 || lsb_rdy !== 1'b0) begin n_err++; $display("FAIL io_held c%0d: got %b/%b want 0/0", c, mem_wr, lsb_rdy); end
    end
    io_full = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000 || mem_dout !== 8'h41) begin n_err++; $display("FAIL io_write: got %b/%h/%h want 1/00030000/41", mem_wr, mem_a, mem_dout); end
    @(negedge clk);
    n_cmp++; if (lsb_rdy !== 1'b1 || mem_wr !== 1'b0) begin n_err++; $display("FAIL io_ack: got %b/%b want 1/0", lsb_rdy, mem_wr); end
    lsb_req = 1'b0;
    model[32'h0003_0000] = 8'h41;
    @(negedge clk);
    n_cmp++; if (wr_count !== w0 + 1) begin n_err++; $display("FAIL io_write_count: got %0d want 1", wr_count - w0); end
    // Blocked I/O store lets a waiting fetch through
    fa = $urandom_range(32'h0000_2FFF, 32'h0000_2000);
    w0 = wr_count;
    io_full = 1'b1;
    lsb_req = 1'b1; r_nw = 1'b0; addr = 32'h0003_0010; din_lsb = 8'h77;
    if_req = 1'b1; if_addr = fa;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (mem_a !== fa) begin n_err++; $display("FAIL io_fetch_bypass: got %h want %h", mem_a, fa); end
      end
      if (c == 6) begin
        n_cmp++; if (if_rdy !== 1'b1 || if_data !== word_at(fa)) begin n_err++; $display("FAIL io_fetch_word: got %b/%h want 1/%h", if_rdy, if_data, word_at(fa)); end
        if_req = 1'b0; lsb_req = 1'b0;
      end
    end
    n_cmp++; if (wr_count !== w0 || lsb_rdy !== 1'b0) begin n_err++; $display("FAIL io_no_store: got %0d writes ack %b want 0/0", wr_count - w0, lsb_rdy); end
    io_full = 1'b0;
    // A non-I/O store is accepted regardless of io_buffer_full
    io_full = 1'b1;
    do_write(32'h0000_0444, 8'h3C);
    io_full = 1'b0;
  endtask

  task automatic test_clear();
    int w0;
    if_req = 1'b1; if_addr = 32'h0000_7000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) begin clr = 1'b1; if_req = 1'b0; end
      if (c == 4) clr = 1'b0;
      n_cmp++; if (if_rdy !== 1'b0) begin n_err++; $display("FAIL clear_fetch c%0d: got %b want 0", c, if_rdy); end
    end
    do_fetch(32'h0000_2000, word_at(32'h0000_2000));
    // No request is accepted while clear is high
    clr = 1'b1; if_req = 1'b1; if_addr = 32'h0000_5000;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_a !== 32'h0000_2003) begin n_err++; $display("FAIL clear_idle c%0d: got %h want 00002003", c, mem_a); end
    end
    clr = 1'b0;
    do_fetch(32'h0000_5000, word_at(32'h0000_5000));
    // Flush during an LSB read
    lsb_req = 1'b1; r_nw = 1'b1; addr = 32'h0000_0600;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) begin clr = 1'b1; lsb_req = 1'b0; end
      if (c == 3) clr = 1'b0;
      n_cmp++; if (lsb_rdy !== 1'b0) begin n_err++; $display("FAIL clear_read c%0d: got %b want 0", c, lsb_rdy); end
    end
    // Flush during a store leaves it committed
    w0 = wr_count;
    lsb_req = 1'b1; r_nw = 1'b0; addr = 32'h0000_0700; din_lsb = 8'h99;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (lsb_rdy !== 1'b1) begin n_err++; $display("FAIL clear_store_ack: got %b want 1", lsb_rdy); end
    clr = 1'b0; lsb_req = 1'b0;
    model[32'h0000_0700] = 8'h99;
    @(negedge clk);
    n_cmp++; if (wr_count !== w0 + 1 || ram_rd(32'h0000_0700) !== 8'h99) begin n_err++; $display("FAIL clear_store: got %0d writes byte %h want 1 99", wr_count - w0, ram_rd(32'h0000_0700)); end
  endtask

  task automatic test_pause();
    int w0;
    logic [31:0] a;
    logic [7:0]  d;
    a = $urandom_range(32'h0000_0FFF, 32'h0000_0800);
    d = 8'($urandom);
    w0 = wr_count;
    lsb_req = 1'b1; r_nw = 1'b0; addr = a; din_lsb = d;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rdy = 1'b0;
        #1;
        n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL pause_gate: got %b want 0", mem_wr); end
      end else if (c <= 4) begin
        n_cmp++; if (mem_wr !== 1'b0 || lsb_rdy !== 1'b0) begin n_err++; $display("FAIL pause_hold c%0d: got %b/%b want 0/0", c, mem_wr, lsb_rdy); end
        if (c == 4) begin
          rdy = 1'b1;
          #1;
          n_cmp++; if (mem_wr !== 1'b1 || mem_a !== a || mem_dout !== d) begin n_err++; $display("FAIL pause_replay: got %b/%h/%h want 1/%h/%h", mem_wr, mem_a, mem_dout, a, d); end
        end
      end else if (c == 5) begin
        n_cmp++; if (lsb_rdy !== 1'b1 || mem_wr !== 1'b0) begin n_err++; $display("FAIL pause_ack: got %b/%b want 1/0", lsb_rdy, mem_wr); end
        lsb_req = 1'b0;
        model[a] = d;
      end else begin
        n_cmp++; if (lsb_rdy !== 1'b0 || wr_count !== w0 + 1 || ram_rd(a) !== d) begin n_err++; $display("FAIL pause_once: got ack %b writes %0d byte %h want 0 1 %h", lsb_rdy, wr_count - w0, ram_rd(a), d); end
      end
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h0000_3000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    if_req = 1'b0;
    #1;
    n_cmp++; if ({mem_a, mem_dout, mem_wr, if_rdy, if_data, lsb_rdy, dout_lsb} !== 83'd0) begin n_err++; $display("FAIL reset_mid: got %h/%h/%b/%b/%h/%b/%h want all 0", mem_a, mem_dout, mem_wr, if_rdy, if_data, lsb_rdy, dout_lsb); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_cmp++; if (if_rdy !== 1'b0 || mem_a !== 32'd0) begin n_err++; $display("FAIL reset_mid_idle: got %b/%h want 0/0", if_rdy, mem_a); end
    end
    do_fetch(32'hFFFF_FFFE, word_at(32'hFFFF_FFFE));
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = 32'h0000_8000 + 32'($urandom_range(15, 0));
      case ($urandom_range(2, 0))
        0:       do_fetch(a, word_at(a));
        1:       do_read(a);
        default: do_write(a, 8'($urandom));
      endcase
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; clr = 1'b0; io_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    lsb_req = 1'b0; r_nw = 1'b1; addr = 32'd0; din_lsb = 8'd0;
    test_reset();
    test_fetch();
    test_lsb();
    test_priority();
    test_io();
    test_clear();
    test_pause();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
